// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive controller
// Purpose: state encoding, baud_select width and reset baud value shared by
//          uart_rx_ctrl and its testbench.
// Ports:   none (package).
package uart_pkg;

  localparam int BAUD_W = 3;

  localparam logic [BAUD_W-1:0] BAUD_DEFAULT_C = 3'b000;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RECONFIG = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - parameterised first-word-fall-through byte FIFO
// Purpose: small FWFT FIFO; head entry is visible on rd_data_o while not empty.
// Ports:   clk, reset (async active-low),
//          push_i/wdata_i  write side, push ignored when full unless popped together,
//          pop_i           pop head, ignored when empty,
//          rd_data_o       head entry (0 when empty),
//          empty_o/full_o/count_o  occupancy decoded from registered count.
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still
  // lands when it is paired with a pop. No bypass when empty.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so wrap is the natural modulo-DEPTH overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver sequencer with byte FIFO and error counters
// Purpose: drives receiver Rx_EN/baud_select, captures bytes on the rising
//          edge of Rx_VALID, counts framing/parity errors, flags overrun and
//          quiesces the receiver around baud changes.
// Ports:   clk, reset (async active-low),
//          cfg_enable/cfg_wr/cfg_baud  host configuration,
//          baud_select/Rx_EN           to receiver,
//          Rx_DATA/Rx_VALID/Rx_FERROR/Rx_PERROR  from receiver,
//          rd_en/rd_data/fifo_empty/fifo_full/fifo_count  host FIFO side,
//          overrun/ferr_cnt/perr_cnt/err_clr  error status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int                FIFO_DEPTH     = 8,
  parameter int                CNT_W          = 8,
  parameter int                QUIESCE_CYCLES = 16,
  parameter logic [BAUD_W-1:0] BAUD_DEFAULT   = BAUD_DEFAULT_C
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_enable,
  input  logic                        cfg_wr,
  input  logic [BAUD_W-1:0]           cfg_baud,
  output logic [BAUD_W-1:0]           baud_select,
  output logic                        Rx_EN,
  input  logic [7:0]                  Rx_DATA,
  input  logic                        Rx_VALID,
  input  logic                        Rx_FERROR,
  input  logic                        Rx_PERROR,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic [CNT_W-1:0]            ferr_cnt,
  output logic [CNT_W-1:0]            perr_cnt,
  input  logic                        err_clr
);

  localparam int QW = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
  localparam logic [QW-1:0]    QCNT_LOAD = QW'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  rx_state_e         state_q;
  logic [QW-1:0]     qcnt_q;
  logic              rx_en_q;
  logic [BAUD_W-1:0] baud_q;
  logic              rx_valid_q;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  ferr_q, ferr_d;
  logic [CNT_W-1:0]  perr_q, perr_d;
  logic              armed, push, drop;

  assign Rx_EN       = rx_en_q;
  assign baud_select = baud_q;
  assign overrun     = overrun_q;
  assign ferr_cnt    = ferr_q;
  assign perr_cnt    = perr_q;

  // cfg_wr wins over every other transition and restarts the quiesce window,
  // so back-to-back baud writes always give the receiver a full quiet period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_DISABLED;
      rx_en_q <= 1'b0;
      baud_q  <= BAUD_DEFAULT;
      qcnt_q  <= '0;
    end else if (cfg_wr) begin
      state_q <= ST_RECONFIG;
      rx_en_q <= 1'b0;
      baud_q  <= cfg_baud;
      qcnt_q  <= QCNT_LOAD;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          if (cfg_enable) begin
            state_q <= ST_ARMED;
            rx_en_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!cfg_enable) begin
            state_q <= ST_DISABLED;
            rx_en_q <= 1'b0;
          end
        end
        ST_RECONFIG: begin
          if (qcnt_q == '0) begin
            state_q <= cfg_enable ? ST_ARMED : ST_DISABLED;
            rx_en_q <= cfg_enable;
          end else begin
            qcnt_q <= qcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_DISABLED;
          rx_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign armed = (state_q == ST_ARMED);

  // Rx_VALID stays high while the line idles, so only its rising edge pushes.
  assign push = Rx_VALID & ~rx_valid_q & armed;
  assign drop = push & fifo_full & ~rd_en;

  always_comb begin
    overrun_d = overrun_q;
    if (err_clr)   overrun_d = 1'b0;
    else if (drop) overrun_d = 1'b1;
  end

  always_comb begin
    ferr_d = ferr_q;
    if (err_clr)
      ferr_d = '0;
    else if (Rx_FERROR && armed && ferr_q != CNT_MAX)
      ferr_d = ferr_q + CNT_W'(1);
  end

  always_comb begin
    perr_d = perr_q;
    if (err_clr)
      perr_d = '0;
    else if (Rx_PERROR && armed && perr_q != CNT_MAX)
      perr_d = perr_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= '0;
      perr_q     <= '0;
    end else begin
      rx_valid_q <= Rx_VALID;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .wdata_i   (Rx_DATA),
    .pop_i     (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_enable;
  logic       cfg_wr;
  logic [2:0] cfg_baud;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [3:0] fifo_count;
  logic       overrun;
  logic [7:0] ferr_cnt;
  logic [7:0] perr_cnt;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(
    .FIFO_DEPTH     (8),
    .CNT_W          (8),
    .QUIESCE_CYCLES (16),
    .BAUD_DEFAULT   (3'b000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_enable  (cfg_enable),
    .cfg_wr      (cfg_wr),
    .cfg_baud    (cfg_baud),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_PERROR   (Rx_PERROR),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
    .ferr_cnt    (ferr_cnt),
    .perr_cnt    (perr_cnt),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    Rx_DATA  = b;
    Rx_VALID = 1'b1;
    tick();
    Rx_VALID = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_b;
    reset      = 1'b0;
    cfg_enable = 1'b0;
    cfg_wr     = 1'b0;
    cfg_baud   = 3'b000;
    Rx_DATA    = 8'h00;
    Rx_VALID   = 1'b0;
    Rx_FERROR  = 1'b0;
    Rx_PERROR  = 1'b0;
    rd_en      = 1'b0;
    err_clr    = 1'b0;
    tick();
    tick();

    chk("rst_rx_en", Rx_EN, 0);
    chk("rst_baud", baud_select, 3'b000);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overrun", overrun, 0);
    chk("rst_ferr", ferr_cnt, 0);
    chk("rst_perr", perr_cnt, 0);

    reset = 1'b1;
    tick();
    chk("disabled_rx_en", Rx_EN, 0);
    cfg_enable = 1'b1;
    tick();
    chk("armed_rx_en", Rx_EN, 1);

    // Rx_VALID held for 5 cycles -> single push
    Rx_DATA  = 8'hA5;
    Rx_VALID = 1'b1;
    tick();
    chk("first_push_empty", fifo_empty, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("held_valid_count", fifo_count, 1);
    chk("held_valid_data", rd_data, 8'hA5);
    Rx_VALID = 1'b0;
    rd_en    = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_empty", fifo_empty, 1);

    // 9 pushes into depth 8 -> overrun, ninth byte dropped
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    chk("ovf_full", fifo_full, 1);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_overrun", overrun, 1);
    for (int i = 1; i <= 8; i++) begin
      exp_b = 8'(i);
      chk("ovf_read", rd_data, exp_b);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("ovf_drained", fifo_empty, 1);
    chk("ovf_sticky", overrun, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", overrun, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    chk("fill_full", fifo_full, 1);
    Rx_DATA  = 8'h55;
    Rx_VALID = 1'b1;
    rd_en    = 1'b1;
    tick();
    Rx_VALID = 1'b0;
    rd_en    = 1'b0;
    chk("pushpop_count", fifo_count, 8);
    chk("pushpop_overrun", overrun, 0);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'h11 + 8'(i) : 8'h55;
      chk("pushpop_read", rd_data, exp_b);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("pushpop_drained", fifo_empty, 1);

    // Baud change with a 16-cycle quiesce
    cfg_baud = 3'b101;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("reconf_baud", baud_select, 3'b101);
    chk("reconf_rx_en_off", Rx_EN, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("reconf_quiet", Rx_EN, 0);
    end
    tick();
    chk("reconf_rearmed", Rx_EN, 1);

    // Second cfg_wr ten cycles into the quiesce restarts the window
    cfg_baud = 3'b101;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    cfg_baud = 3'b010;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("restart_baud", baud_select, 3'b010);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("restart_quiet", Rx_EN, 0);
    end
    tick();
    chk("restart_rearmed", Rx_EN, 1);

    // Framing error saturation
    for (int i = 0; i < 300; i++) begin
      Rx_FERROR = 1'b1;
      tick();
      Rx_FERROR = 1'b0;
      tick();
    end
    chk("ferr_saturated", ferr_cnt, 8'd255);
    chk("perr_untouched", perr_cnt, 0);

    err_clr = 1'b1;
    tick();
    err_clr   = 1'b0;
    Rx_FERROR = 1'b1;
    Rx_PERROR = 1'b1;
    tick();
    Rx_FERROR = 1'b0;
    Rx_PERROR = 1'b0;
    chk("both_ferr", ferr_cnt, 1);
    chk("both_perr", perr_cnt, 1);
    Rx_PERROR = 1'b1;
    err_clr   = 1'b1;
    tick();
    Rx_PERROR = 1'b0;
    err_clr   = 1'b0;
    chk("clr_prio_perr", perr_cnt, 0);
    chk("clr_prio_ferr", ferr_cnt, 0);

    // Errors ignored while disabled
    cfg_enable = 1'b0;
    tick();
    chk("disable_rx_en", Rx_EN, 0);
    Rx_FERROR = 1'b1;
    Rx_VALID  = 1'b1;
    Rx_DATA   = 8'h77;
    tick();
    Rx_FERROR = 1'b0;
    Rx_VALID  = 1'b0;
    chk("disabled_no_ferr", ferr_cnt, 0);
    chk("disabled_no_push", fifo_empty, 1);
    cfg_enable = 1'b1;
    tick();
    chk("reenable_rx_en", Rx_EN, 1);
    tick();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) push_byte(8'h31 + 8'(i));
    Rx_FERROR = 1'b1;
    tick();
    Rx_FERROR = 1'b0;
    chk("pre_rst_count", fifo_count, 3);
    chk("pre_rst_ferr", ferr_cnt, 1);
    Rx_DATA  = 8'h99;
    Rx_VALID = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_empty", fifo_empty, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_rx_en", Rx_EN, 0);
    chk("mid_rst_ferr", ferr_cnt, 0);
    chk("mid_rst_baud", baud_select, 3'b000);
    Rx_VALID = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequences the UART receiver: drives its Rx_EN and baud_select, and captures each received byte into a small first-word-fall-through FIFO.
- Counts framing and parity errors and flags overruns.
- Applies baud-rate changes safely by quiescing the receiver first.
- Sits between the receiver and the consuming host logic.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating error counters.
- QUIESCE_CYCLES, 16, clk cycles Rx_EN is held low during reconfiguration; minimum 1.
- BAUD_DEFAULT, 3'b000, baud_select value after reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cfg_enable  input  1  level; 1 = reception wanted.
- cfg_wr  input  1  one-cycle strobe; load cfg_baud.
- cfg_baud  input  3  new baud selection.
- baud_select  output  3  to receiver baud_select.
- Rx_EN  output  1  to receiver Rx_EN.
- Rx_DATA  input  8  receiver data.
- Rx_VALID  input  1  receiver valid level; stays high while the line idles after a frame.
- Rx_FERROR  input  1  receiver framing-error pulse.
- Rx_PERROR  input  1  receiver parity-error pulse.
- rd_en  input  1  pop FIFO head.
- rd_data  output  8  FIFO head; valid when fifo_empty = 0.
- fifo_empty  output  1  FIFO holds 0 entries.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
- overrun  output  1  sticky; a byte was dropped because the FIFO was full.
- ferr_cnt  output  CNT_W  saturating framing-error count.
- perr_cnt  output  CNT_W  saturating parity-error count.
- err_clr  input  1  one-cycle strobe; clears overrun, ferr_cnt and perr_cnt.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State DISABLED; Rx_EN = 0; baud_select = BAUD_DEFAULT.
  - FIFO empty: fifo_empty = 1, fifo_full = 0, fifo_count = 0, rd_data = 0.
  - overrun = 0; both counters = 0; valid_d (registered Rx_VALID) = 0.
  - A reset mid-frame discards the partial byte and all FIFO contents.
- States:
  - DISABLED: Rx_EN = 0. cfg_enable = 1 -> ARMED next cycle.
  - ARMED: Rx_EN = 1. cfg_enable = 0 -> DISABLED next cycle; any frame in progress is abandoned.
  - RECONFIG: Rx_EN = 0. A down-counter is loaded with QUIESCE_CYCLES-1 on entry. At 0, go to ARMED if cfg_enable = 1, else DISABLED.
  - cfg_wr (any state, including RECONFIG):
    - baud_select <= cfg_baud on the next edge.
    - Enter RECONFIG and reload the counter.
    - cfg_wr has priority over the cfg_enable transitions.
- Capture:
  - push = Rx_VALID & ~valid_d & (state == ARMED). Only the rising edge is used; a held Rx_VALID does not push again.
  - The byte is written at the clk edge ending the push cycle. fifo_empty falls 1 cycle after the Rx_VALID rise.
- FIFO:
  - rd_data is combinational from the head entry.
  - rd_en when empty is ignored.
  - Push when full:
    - Without a same-cycle rd_en: byte dropped, overrun <= 1, contents unchanged.
    - With a same-cycle rd_en: pop and push both take effect; count unchanged; no overrun.
  - Push and pop together when empty: push only (no fall-through bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- Error counters:
  - Increment by 1 in every cycle where the corresponding pulse is high and state == ARMED.
  - Saturate at 2^CNT_W-1.
  - err_clr takes priority over a same-cycle increment; the result is 0.
  - FERROR and PERROR in the same cycle increment both counters.
- All outputs are registered except rd_data, fifo_empty, fifo_full and fifo_count, which decode registered pointers and count.

Decomposition:
- Shared package uart_pkg:
  - state encoding DISABLED/ARMED/RECONFIG.
  - baud_select width (3).
  - BAUD_DEFAULT constant.
- One natural sub-module: uart_byte_fifo, a parameterised FWFT FIFO with push/pop/full/empty/count.
- The controller FSM, edge detect and counters stay in uart_rx_ctrl.

Test Plan:
- Reset, then cfg_enable = 1: Rx_EN = 1 one cycle later. Pulse Rx_VALID high for 5 cycles with Rx_DATA = 8'hA5 -> exactly one push; fifo_count = 1, rd_data = 8'hA5. Pop -> fifo_empty = 1.
- With FIFO_DEPTH = 8, push 9 bytes 8'h01..8'h09 without reads -> fifo_full = 1, overrun = 1. Reads return 8'h01..8'h08. Then err_clr -> overrun = 0.
- Fill to 8, then push 8'h55 with rd_en in the same cycle -> fifo_count stays 8, overrun stays 0, last entry read is 8'h55.
- cfg_wr with cfg_baud = 3'b101 while ARMED -> baud_select = 3'b101 next cycle, Rx_EN = 0 for 16 cycles, then 1. A second cfg_wr at cycle 10 restarts the 16-cycle quiesce.
- Drive Rx_FERROR for 300 single-cycle pulses with CNT_W = 8 -> ferr_cnt = 255. Rx_PERROR pulse together with err_clr -> perr_cnt = 0.
- Assert reset mid-stream with 3 bytes queued and the receiver mid-frame -> immediately fifo_empty = 1, Rx_EN = 0, counters 0, baud_select = 3'b000.
